// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types, constants and helpers for the hazard controller
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } stage_tag_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

    // True when the tagged instruction will write a non-zero rd equal to rs.
    function automatic logic writes_reg(input stage_tag_t tag, input logic [4:0] rs);
        return tag.valid && tag.reg_write && (tag.rd != REG_ZERO) && (tag.rd == rs);
    endfunction

    // Operand source for an ID operand, judged one cycle before it reaches EX.
    function automatic fwd_sel_e fwd_select(input stage_tag_t ex_tag, input stage_tag_t mem_tag,
                                            input logic [4:0] rs);
        fwd_sel_e sel;
        sel = FWD_REG;
        if (rs == REG_ZERO) begin
            sel = FWD_REG;
        end else if (writes_reg(ex_tag, rs) && !ex_tag.mem_read) begin
            sel = FWD_MEM;
        end else if (writes_reg(mem_tag, rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        return (en && (value != CNT_MAX)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// rtl/stage_tag_reg.sv - one pipeline shadow tag register with bubble insert
module stage_tag_reg
    import hazard_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       bubble,
    input  stage_tag_t tag_in,
    output stage_tag_t tag_out
);

    stage_tag_t tag_d;
    stage_tag_t tag_q;

    always_comb begin
        tag_d = tag_in;
        if (bubble) begin
            tag_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use stall, branch flush and operand forwarding control
module hazard_controller
    import hazard_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        ex_branch_taken,
    output logic        stall_if_id,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    stage_tag_t id_tag;
    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    stage_tag_t wb_tag;

    logic load_use;
    logic ex_bubble;

    fwd_sel_e fwd_a_d;
    fwd_sel_e fwd_a_q;
    fwd_sel_e fwd_b_d;
    fwd_sel_e fwd_b_q;

    logic [31:0] stall_count_d;
    logic [31:0] stall_count_q;
    logic [31:0] flush_count_d;
    logic [31:0] flush_count_q;

    assign id_tag = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};

    // WB is tracked for completeness only: the register file writes through.
    logic unused_wb_tag;
    assign unused_wb_tag = ^wb_tag;

    stage_tag_reg u_ex_tag (
        .clk     (clk),
        .rst     (rst),
        .bubble  (ex_bubble),
        .tag_in  (id_tag),
        .tag_out (ex_tag)
    );

    stage_tag_reg u_mem_tag (
        .clk     (clk),
        .rst     (rst),
        .bubble  (1'b0),
        .tag_in  (ex_tag),
        .tag_out (mem_tag)
    );

    stage_tag_reg u_wb_tag (
        .clk     (clk),
        .rst     (rst),
        .bubble  (1'b0),
        .tag_in  (mem_tag),
        .tag_out (wb_tag)
    );

    // A taken branch wins over a load-use stall; reset masks every control output.
    always_comb begin
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        load_use    = id_valid && ex_tag.mem_read &&
                      (writes_reg(ex_tag, id_rs1) || writes_reg(ex_tag, id_rs2));
        ex_bubble   = ex_branch_taken || load_use || !id_valid;
        if (!rst) begin
            if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (!ex_bubble) begin
            fwd_a_d = fwd_select(ex_tag, mem_tag, id_rs1);
            fwd_b_d = fwd_select(ex_tag, mem_tag, id_rs2);
        end
    end

    always_comb begin
        stall_count_d = sat_inc(stall_count_q, stall_if_id);
        flush_count_d = sat_inc(flush_count_q, ex_branch_taken);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q       <= FWD_REG;
            fwd_b_q       <= FWD_REG;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fwd_a_sel   = fwd_a_q;
    assign fwd_b_sel   = fwd_b_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 id_valid  in  1  ID stage holds a real instruction.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the ID instruction.
REQ-006 id_rd  in  5  destination register of the ID instruction.
REQ-007 id_reg_write, id_mem_read  in  1 each  ID instruction writes rd / is a load.
REQ-008 ex_branch_taken  in  1  EX-stage branch or jump redirects the PC this cycle.
REQ-009 stall_if_id  out  1  hold the PC and the IF/ID register.
REQ-010 flush_if_id, flush_id_ex  out  1 each  replace the stage register contents with a bubble.
REQ-011 fwd_a_sel, fwd_b_sel  out  2 each  EX operand mux select: 00 register value, 01 MEM-stage ALU result, 10 WB result, 11 never driven.
REQ-012 stall_count, flush_count  out  32 each  saturating event counters.

Function
REQ-013 The block SHALL keep shadow tags {valid, rd, reg_write, mem_read} for the EX, MEM and WB stages, advancing ID->EX->MEM->WB every cycle.
REQ-014 Load-use hazard: the hazard SHALL be asserted when all of the following hold: id_valid; EX tag valid; EX mem_read=1; EX reg_write=1; EX rd!=0; EX rd equals id_rs1 or id_rs2.
REQ-015 On a load-use hazard without a taken branch: stall_if_id=1 and flush_id_ex=1 in the same cycle (combinational), and the EX tag SHALL load a bubble (valid=0) instead of the ID tag.
REQ-016 On ex_branch_taken=1: flush_if_id=1 and flush_id_ex=1, stall_if_id=0, and the EX tag SHALL load a bubble; a branch SHALL take priority over a load-use stall.
REQ-017 Forward selects SHALL be computed from the ID operands and registered into fwd_a_sel/fwd_b_sel when the ID tag advances into EX, giving one cycle of latency.
REQ-018 Operand select priority:
  - 01 when the current EX tag is valid, has reg_write=1, mem_read=0, rd!=0 and rd==rs;
  - else 10 when the current MEM tag is valid, has reg_write=1, rd!=0 and rd==rs;
  - else 00.
REQ-019 A source register x0 SHALL always yield select 00.
REQ-020 When a bubble enters EX (stall or flush), fwd_a_sel and fwd_b_sel SHALL load 00.
REQ-021 The register file writes through in the same cycle, so a WB-to-ID dependency SHALL need no forward and no stall.
REQ-022 id_valid=0 SHALL produce no stall and a bubble EX tag.
REQ-023 stall_count SHALL increment in each cycle stall_if_id=1 and saturate at 0xFFFF_FFFF.
REQ-024 flush_count SHALL increment in each cycle ex_branch_taken=1 and saturate at 0xFFFF_FFFF.
REQ-025 Output select value 11 SHALL never be produced.

Reset
REQ-026 While rst=1, all shadow tags SHALL be invalid, fwd_a_sel=fwd_b_sel=00, and both counters SHALL be 0.
REQ-027 While rst=1, stall_if_id, flush_if_id and flush_id_ex SHALL be 0 regardless of inputs.
REQ-028 Reset asserted mid-stall or mid-flush SHALL discard all in-flight tags; the first cycle after reset SHALL behave as if the pipeline were empty.

Structure
REQ-029 A shared package SHALL define:
  - enum fwd_sel_e {FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10};
  - struct stage_tag_t {valid, rd[4:0], reg_write, mem_read};
  - the constant REG_ZERO=5'd0.
REQ-030 One sub-module, stage_tag_reg (a stage_tag_t register with synchronous reset and bubble insert), SHALL be instantiated for each of the EX, MEM and WB tags.
REQ-031 The hazard and forward decisions SHALL be single always_comb blocks; all state SHALL be in always_ff blocks.

Verification
REQ-032 Scenario ALU chain: add x5 writes in ID, next instruction uses rs1=x5 -> on the next cycle fwd_a_sel=01, no stall.
REQ-033 Scenario distance two: x6 written, one independent instruction, then rs2=x6 -> fwd_b_sel=10, fwd_a_sel=00.
REQ-034 Scenario load-use: lw x7 in EX, ID rs1=x7 -> for one cycle stall_if_id=1 and flush_id_ex=1; after the stall fwd_a_sel=10; stall_count=1.
REQ-035 Scenario branch vs. stall: ex_branch_taken=1 together with a load-use match -> stall_if_id=0, flush_if_id=flush_id_ex=1, flush_count increments, stall_count unchanged.
REQ-036 Scenario x0 write: rd=0 with reg_write=1 followed by rs1=0 -> fwd_a_sel=00, no stall.
REQ-037 Scenario reset and saturation: assert rst during a stall -> all outputs 0 the next cycle; preload stall_count=0xFFFF_FFFF, then stall -> value holds at 0xFFFF_FFFF.
